// File: rtl/bk_serial_subtractor.sv
// Digit-serial subtractor: D = A - B - BIN, one nibble per clock, LSB nibble first,
// each nibble resolved by a 4-bit Brent-Kung prefix network. Define SIGNED_OVF_EN for signed overflow.
module bk_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic             c_q, c_d, bout_q, bout_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
`ifdef SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [CW+1:0] base;
    logic [3:0]    p, g, s;
    logic          g10, p10, g32, p32, c1, c2, c3, c4;

    // Nibble-level Brent-Kung prefix on A + ~B + carry.
    always_comb begin
        base = {cnt_q, 2'b00};
        p    = a_q[base +: 4] ^ ~b_q[base +: 4];
        g    = a_q[base +: 4] & ~b_q[base +: 4];
        g10  = g[1] | (p[1] & g[0]);
        p10  = p[1] & p[0];
        g32  = g[3] | (p[3] & g[2]);
        p32  = p[3] & p[2];
        c1   = g[0] | (p[0] & c_q);
        c2   = g10 | (p10 & c_q);
        c3   = g[2] | (p[2] & c2);
        c4   = g32 | (p32 & c2);
        s    = p ^ {c3, c2, c1, c_q};
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = ~bin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                d_d[base +: 4] = s;
                c_d            = c4;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = ~c4;
`ifdef SIGNED_OVF_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (s[3] != a_q[WIDTH-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            d_q         <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            bout_q      <= bout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef SIGNED_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
`ifdef SIGNED_OVF_EN
    assign ovf       = ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: doc/bk_serial_subtractor.md
Name: bk_serial_subtractor

Overview:
- Digit-serial subtractor. Computes D = A - B - BIN over a WIDTH-bit operand, one 4-bit nibble per clock, LSB nibble first.
- Each nibble is resolved by a 4-bit Brent-Kung prefix network with carry-in.
- Subtraction is implemented as A + ~B + ~BIN; the borrow chain is carried between nibbles in a register.
- Provides the subtract path for the adder datapath, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4. NIB = WIDTH/4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference.
- bout  output  1  borrow out (1 = a < b + bin, unsigned).
- ovf  output  1  signed overflow; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - in_ready=1, out_valid=0, d=0, bout=0, ovf=0.
  - Nibble counter=0, borrow register=0.
  - Reset takes priority over all other events and aborts any operation in progress, with no result produced.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge:
    - latch a, b.
    - carry register=~bin.
    - counter=0.
    - go to CALC.
  - CALC: in_ready=0, out_valid=0. Each edge processes nibble k=counter:
    - p=a[k]^~b[k], g=a[k]&~b[k].
    - Prefix terms: g10=g1|p1&g0, g32=g3|p3&g2, p10, p32, p30; carry-in c.
    - Carries: c1=g0|p0&c, c2=g10|p10&c, c3=g2|p2&c2, c4=g32|p32&c2.
    - Sum: s[i]=p[i]^c[i].
    - d nibble k <= s; carry register <= c4; counter++.
    - When k==NIB-1: go to DONE and set bout=~c4.
  - DONE: out_valid=1, in_ready=0.
    - d, bout and ovf are held stable.
    - On out_ready at an edge: go to IDLE. out_valid drops the next cycle.
- Timing:
  - Latency: out_valid is high in the cycle following the NIB-th edge after the accept edge (16-bit: 4 clocks).
  - Throughput: one result per NIB+2 cycles. No overlap; in_ready is high only in IDLE.
- Inputs a/b/bin are sampled only at the accept edge; later changes are ignored.
- in_valid outside IDLE is ignored (no queuing).
- d holds its last result after DONE until the next accept. d is not cleared in IDLE, only by reset.
- bout is unsigned borrow: a=b, bin=0 gives d=0, bout=0; a=0, b=0, bin=1 gives d=all-ones, bout=1.
- WIDTH=4 is legal: a single CALC cycle.

Optional Feature:
- Macro SIGNED_OVF_EN.
- Defined:
  - The MSBs of a and b are latched at accept.
  - On entry to DONE: ovf=(a_msb!=b_msb)&&(d_msb!=a_msb), computed from the final d.
  - ovf is held during DONE and has the same reset and hold rules as bout.
- Undefined: ovf is tied to 0 and no extra registers exist.

Test Plan:
- WIDTH=16; accept a=0x1234, b=0x0235, bin=0 -> d=0x0FFF, bout=0; out_valid rises exactly 4 clocks after the accept edge; in_ready=0 throughout.
- a=0x0000, b=0x0001, bin=0 -> d=0xFFFF, bout=1; the borrow propagates through all 4 nibbles. Then a=0x5A5A, b=0x5A5A, bin=0 -> d=0x0000, bout=0.
- a=0x8000, b=0x0000, bin=1 -> d=0x7FFF, bout=0; ovf=1 with SIGNED_OVF_EN, ovf=0 without.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while toggling in_valid with new operands.
  - Required: d, bout and ovf stay unchanged; in_ready=0; the new operands are not taken.
  - After out_ready=1: IDLE the next cycle, then the next accept proceeds normally.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 after 2 CALC edges.
  - Required: the next cycle shows in_ready=1, out_valid=0, d=0, bout=0.
  - A subsequent a=0x0010, b=0x0001, bin=0 -> d=0x000F, bout=0.
- out_ready tied 1, in_valid tied 1, random operands for 200 ops:
  - Every result equals a-b-bin mod 2^16, with bout matching the reference model.
  - Accepts are spaced exactly 6 cycles apart.
